cpu_status_flags: RTL and testbench

- Processor status register (P) for the 6502 core, sitting on the flag side of the ALU.
- Latches the ALU's neg/ov/zero/carry results under decoder control and feeds carry and decimal mode back to the ALU.
- Services PLP/RTI loads, PHP/BRK pushes and BIT flag loads.
- Holds the interrupt-poll logic: NMI edge latch, IRQ masking by I, and polling at instruction boundaries.

---
 rtl/cpu_status_flags_pkg.sv | 38 +++
 rtl/cpu_status_flags_int_poll.sv | 65 ++++++
 rtl/cpu_status_flags.sv | 109 ++++++++++
 tb/tb_cpu_status_flags.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_status_flags_pkg.sv
// Shared 6502 CPU definitions: processor status (P) bit positions and flag storage type.
package cpu_status_flags_pkg;

  localparam int unsigned P_W = 8;
  localparam int unsigned P_C = 0;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_5 = 5;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_N = 7;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  // Assemble the architectural P byte; B and bit 5 are not stored state.
  function automatic logic [P_W-1:0] pack_p(input flags_t f, input logic p5, input logic b);
    logic [P_W-1:0] p;
    p      = '0;
    p[P_N] = f.n;
    p[P_V] = f.v;
    p[P_5] = p5;
    p[P_B] = b;
    p[P_D] = f.d;
    p[P_I] = f.i;
    p[P_Z] = f.z;
    p[P_C] = f.c;
    return p;
  endfunction

endpackage

// File: rtl/cpu_status_flags_int_poll.sv
// Interrupt poll: NMI falling-edge latch, IRQ masking and request hold until acknowledge.
module cpu_int_poll (
  input  logic clk,
  input  logic rst,
  input  logic instr_done,
  input  logic int_ack,
  input  logic irq_n,
  input  logic nmi_n,
  input  logic flag_i,
  output logic int_req,
  output logic int_is_nmi
);

  logic nmi_prev;
  logic nmi_pending;
  logic nmi_fall;
  logic pending_d;
  logic req_d;
  logic is_nmi_d;

  assign nmi_fall = nmi_prev & ~nmi_n;

  // A fresh edge in the acknowledge cycle must survive the clear.
  always_comb begin
    pending_d = nmi_pending;
    if (nmi_fall) begin
      pending_d = 1'b1;
    end else if (int_ack && int_is_nmi) begin
      pending_d = 1'b0;
    end
  end

  // flag_i is the registered I, so the poll sees the pre-update value.
  always_comb begin
    req_d    = int_req;
    is_nmi_d = int_is_nmi;
    if (int_ack) begin
      req_d    = 1'b0;
      is_nmi_d = 1'b0;
    end else if (instr_done && !int_req) begin
      if (nmi_pending) begin
        req_d    = 1'b1;
        is_nmi_d = 1'b1;
      end else if (!irq_n && !flag_i) begin
        req_d    = 1'b1;
        is_nmi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_prev    <= 1'b1;
      nmi_pending <= 1'b0;
      int_req     <= 1'b0;
      int_is_nmi  <= 1'b0;
    end else begin
      nmi_prev    <= nmi_n;
      nmi_pending <= pending_d;
      int_req     <= req_d;
      int_is_nmi  <= is_nmi_d;
    end
  end

endmodule

// File: rtl/cpu_status_flags.sv
// 6502 processor status register: ALU flag capture, PLP/BIT loads, explicit flag ops, interrupt poll.
module cpu_status_flags
  import cpu_status_flags_pkg::*;
#(
  parameter logic RESET_D  = 1'b0,
  parameter logic RESET_P5 = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alu_neg,
  input  logic           alu_ov,
  input  logic           alu_zero,
  input  logic           alu_carry,
  input  logic           upd_nz,
  input  logic           upd_c,
  input  logic           upd_v,
  input  logic           bit_load,
  input  logic           set_c,
  input  logic           clr_c,
  input  logic           set_i,
  input  logic           clr_i,
  input  logic           set_d,
  input  logic           clr_d,
  input  logic           clr_v,
  input  logic           load_p,
  input  logic [P_W-1:0] data_in,
  input  logic           push_brk,
  input  logic           instr_done,
  input  logic           int_ack,
  input  logic           irq_n,
  input  logic           nmi_n,
  output logic [P_W-1:0] p_out,
  output logic           flag_c,
  output logic           flag_d,
  output logic           int_req,
  output logic           int_is_nmi
);

  flags_t     f_q;
  flags_t     f_d;
  logic [1:0] unused_data_bits;

  // PLP/RTI ignore the B and bit-5 positions of the pulled byte.
  assign unused_data_bits = data_in[P_5:P_B];

  // Per-flag priority: interrupt entry, then pull, then explicit ops, then BIT, then ALU.
  always_comb begin
    f_d = f_q;
    if (int_ack) begin
      f_d.i = 1'b1;
    end else if (load_p) begin
      f_d.n = data_in[P_N];
      f_d.v = data_in[P_V];
      f_d.d = data_in[P_D];
      f_d.i = data_in[P_I];
      f_d.z = data_in[P_Z];
      f_d.c = data_in[P_C];
    end else begin
      if (set_c)      f_d.c = 1'b1;
      else if (clr_c) f_d.c = 1'b0;
      else if (upd_c) f_d.c = alu_carry;

      if (set_i)      f_d.i = 1'b1;
      else if (clr_i) f_d.i = 1'b0;

      if (set_d)      f_d.d = 1'b1;
      else if (clr_d) f_d.d = 1'b0;

      if (clr_v)         f_d.v = 1'b0;
      else if (bit_load) f_d.v = data_in[P_V];
      else if (upd_v)    f_d.v = alu_ov;

      if (bit_load) begin
        f_d.n = data_in[P_N];
        f_d.z = alu_zero;
      end else if (upd_nz) begin
        f_d.n = alu_neg;
        f_d.z = alu_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q   <= '0;
      f_q.i <= 1'b1;
      f_q.d <= RESET_D;
    end else begin
      f_q   <= f_d;
    end
  end

  assign p_out  = pack_p(f_q, RESET_P5, push_brk);
  assign flag_c = f_q.c;
  assign flag_d = f_q.d;

  cpu_int_poll u_int_poll (
    .clk        (clk),
    .rst        (rst),
    .instr_done (instr_done),
    .int_ack    (int_ack),
    .irq_n      (irq_n),
    .nmi_n      (nmi_n),
    .flag_i     (f_q.i),
    .int_req    (int_req),
    .int_is_nmi (int_is_nmi)
  );

endmodule

// File: tb/tb_cpu_status_flags.sv
// Self-checking bench for cpu_status_flags: directed scenarios plus randomized traffic vs a behavioural model.
module tb_cpu_status_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_neg, alu_ov, alu_zero, alu_carry;
  logic       upd_nz, upd_c, upd_v, bit_load;
  logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
  logic       load_p;
  logic [7:0] data_in;
  logic       push_brk, instr_done, int_ack, irq_n, nmi_n;
  logic [7:0] p_out;
  logic       flag_c, flag_d, int_req, int_is_nmi;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: P held as a byte, interrupt side as plain bits.
  logic [7:0] m_p;
  bit m_nprev, m_pend, m_req, m_isnmi;

  cpu_status_flags dut (
    .clk(clk), .rst(rst),
    .alu_neg(alu_neg), .alu_ov(alu_ov), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_load(bit_load),
    .set_c(set_c), .clr_c(clr_c), .set_i(set_i), .clr_i(clr_i),
    .set_d(set_d), .clr_d(clr_d), .clr_v(clr_v),
    .load_p(load_p), .data_in(data_in), .push_brk(push_brk),
    .instr_done(instr_done), .int_ack(int_ack), .irq_n(irq_n), .nmi_n(nmi_n),
    .p_out(p_out), .flag_c(flag_c), .flag_d(flag_d),
    .int_req(int_req), .int_is_nmi(int_is_nmi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_p();
    logic [7:0] e;
    e = m_p;
    e[5] = 1'b1;
    e[4] = push_brk;
    return e;
  endfunction

  task automatic model_reset();
    m_p     = 8'h04;
    m_nprev = 1'b1;
    m_pend  = 1'b0;
    m_req   = 1'b0;
    m_isnmi = 1'b0;
  endtask

  // One rising edge of the status register, straight from the flag/interrupt rules.
  task automatic model_step();
    bit fall, pend, req, isnmi;
    logic [7:0] np;
    if (rst) begin
      model_reset();
      return;
    end
    fall  = m_nprev && !nmi_n;
    pend  = fall ? 1'b1 : ((int_ack && m_isnmi) ? 1'b0 : m_pend);
    req   = m_req;
    isnmi = m_isnmi;
    if (int_ack) begin
      req = 0; isnmi = 0;
    end else if (instr_done && !m_req) begin
      if (m_pend) begin req = 1; isnmi = 1; end
      else if (!irq_n && !m_p[2]) begin req = 1; isnmi = 0; end
    end
    np = m_p;
    if (int_ack) np[2] = 1'b1;
    else if (load_p) np = data_in & 8'hCF;
    else begin
      if (upd_nz) begin np[7] = alu_neg; np[1] = alu_zero; end
      if (upd_c) np[0] = alu_carry;
      if (upd_v) np[6] = alu_ov;
      if (bit_load) begin np[7] = data_in[7]; np[6] = data_in[6]; np[1] = alu_zero; end
      if (clr_c) np[0] = 1'b0;
      if (set_c) np[0] = 1'b1;
      if (clr_i) np[2] = 1'b0;
      if (set_i) np[2] = 1'b1;
      if (clr_d) np[3] = 1'b0;
      if (set_d) np[3] = 1'b1;
      if (clr_v) np[6] = 1'b0;
    end
    m_p = np; m_nprev = nmi_n; m_pend = pend; m_req = req; m_isnmi = isnmi;
  endtask

  task automatic idle();
    {alu_neg, alu_ov, alu_zero, alu_carry} = '0;
    {upd_nz, upd_c, upd_v, bit_load} = '0;
    {set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v} = '0;
    load_p = 0; data_in = 8'h00; push_brk = 0; instr_done = 0; int_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    idle();
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("p_out", p_out, exp_p());
      check("flag_c", 8'(flag_c), 8'(m_p[0]));
      check("flag_d", 8'(flag_d), 8'(m_p[3]));
      check("int_req", 8'(int_req), 8'(m_req));
      check("int_is_nmi", 8'(int_is_nmi), 8'(m_isnmi));
    end
  end

  task automatic rand_cycle();
    alu_neg = 1'($urandom); alu_ov = 1'($urandom);
    alu_zero = 1'($urandom); alu_carry = 1'($urandom);
    upd_nz = ($urandom_range(3) == 0); upd_c = ($urandom_range(3) == 0);
    upd_v = ($urandom_range(5) == 0); bit_load = ($urandom_range(9) == 0);
    set_c = ($urandom_range(7) == 0); clr_c = ($urandom_range(7) == 0);
    set_i = ($urandom_range(11) == 0); clr_i = ($urandom_range(5) == 0);
    set_d = ($urandom_range(7) == 0); clr_d = ($urandom_range(7) == 0);
    clr_v = ($urandom_range(7) == 0); load_p = ($urandom_range(15) == 0);
    data_in = 8'($urandom); push_brk = 1'($urandom);
    instr_done = ($urandom_range(3) == 0);
    int_ack = m_req ? ($urandom_range(2) == 0) : ($urandom_range(31) == 0);
    if ($urandom_range(15) == 0) irq_n = ~irq_n;
    if ($urandom_range(7) == 0) nmi_n = ~nmi_n;
  endtask

  initial begin
    rst = 1'b1; irq_n = 1'b1; nmi_n = 1'b1;
    idle();
    model_reset();
    tick(); tick();
    check("rst_p_out", p_out, 8'h24);
    check("rst_flag_c", 8'(flag_c), 8'h00);
    check("rst_int_req", 8'(int_req), 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;

    // ALU capture, then clear-carry outranking the ALU carry.
    upd_nz = 1; upd_c = 1; alu_neg = 1; alu_zero = 0; alu_carry = 1;
    tick();
    check("alu_nzcv", p_out & 8'hC3, 8'h81);
    check("alu_flag_c", 8'(flag_c), 8'h01);
    clr_c = 1; upd_c = 1; alu_carry = 1;
    tick();
    check("clr_c_wins", 8'(flag_c), 8'h00);

    // PLP of FF, then BIT of 40.
    load_p = 1; data_in = 8'hFF;
    tick();
    check("plp_b0", p_out, 8'hEF);
    push_brk = 1; #1;
    check("plp_b1", p_out, 8'hFF);
    push_brk = 0;
    bit_load = 1; data_in = 8'h40; alu_zero = 1;
    tick();
    check("bit_nvz", p_out & 8'hC2, 8'h42);

    // CLI: IRQ only seen one instruction later.
    irq_n = 0; clr_i = 1; instr_done = 1;
    tick();
    check("cli_no_req", 8'(int_req), 8'h00);
    instr_done = 1;
    tick();
    check("cli_req", {int_req, int_is_nmi}, 8'h02);
    int_ack = 1;
    tick();
    check("ack_req", 8'(int_req), 8'h00);
    check("ack_i", p_out & 8'h04, 8'h04);

    // NMI outranks IRQ, fires once per edge.
    clr_i = 1;
    tick();
    nmi_n = 0;
    tick();
    instr_done = 1;
    tick();
    check("nmi_req", {int_req, int_is_nmi}, 8'h03);
    int_ack = 1;
    tick();
    instr_done = 1;
    tick();
    check("nmi_once", 8'(int_req), 8'h00);

    // New NMI edge coincident with acknowledge keeps it pending.
    nmi_n = 1;
    tick();
    nmi_n = 0;
    tick();
    instr_done = 1;
    tick();
    check("nmi2_req", {int_req, int_is_nmi}, 8'h03);
    nmi_n = 1;
    tick();
    nmi_n = 0; int_ack = 1;
    tick();
    check("nmi2_ack", 8'(int_req), 8'h00);
    instr_done = 1;
    tick();
    check("nmi3_req", {int_req, int_is_nmi}, 8'h03);
    int_ack = 1;
    tick();

    for (int k = 0; k < 3000; k++) begin
      rand_cycle();
      tick();
    end

    // Mid-cycle asynchronous reset drops any request.
    #2 rst = 1; push_brk = 0;
    model_reset();
    #1;
    check("mid_rst_p", p_out, 8'h24);
    check("mid_rst_c", 8'(flag_c), 8'h00);
    check("mid_rst_req", {int_req, int_is_nmi}, 8'h00);
    tick();
    rst = 0;
    for (int k = 0; k < 500; k++) begin
      rand_cycle();
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
